// File: rtl/ob_pkg.sv
// Shared order-book command types used between dispatch, conditional table and matcher.
package ob_pkg;
    typedef enum logic [3:0] {
        OP_NOP             = 4'd0,
        OP_BUY_LIMIT       = 4'd1,
        OP_SELL_LIMIT      = 4'd2,
        OP_BUY_MARKET      = 4'd3,
        OP_SELL_MARKET     = 4'd4,
        OP_BUY_STOP_LOSS   = 4'd5,
        OP_SELL_STOP_LOSS  = 4'd6,
        OP_BUY_STOP_LIMIT  = 4'd7,
        OP_SELL_STOP_LIMIT = 4'd8
    } opcode_t;

    typedef struct packed {
        opcode_t     op;
        logic [15:0] oid;
        logic [31:0] price;
        logic [15:0] qty;
    } cmd_t;
endpackage

// File: rtl/ob_cn_table_ctrl.sv
// Conditional-table controller: allocates stop commands to the lowest free entry and issues matured
// entries round-robin through a 1-deep output register (held stable under backpressure), 1-cycle latency.
module ob_cn_table_ctrl #(
    parameter int N     = 8,
    parameter int IDX_W = $clog2(N)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_vld,
    input  ob_pkg::cmd_t               in_cmd,
    output logic                       in_rdy,
    output logic [N-1:0]               ent_al_vld,
    output ob_pkg::cmd_t               ent_al_cmd_r,
    output logic [N-1:0]               ent_dl_vld,
    input  logic [N-1:0]               ent_mtr_vld_r,
    input  ob_pkg::cmd_t [N-1:0]       ent_cmd_r,
    output logic                       out_vld,
    output ob_pkg::cmd_t               out_cmd,
    output logic [IDX_W-1:0]           out_idx,
    input  logic                       out_rdy,
    output logic [$clog2(N+1)-1:0]     occ_cnt_r,
    output logic                       full_r,
    output logic                       empty_r,
    output logic                       err_r
);
    localparam int CNT_W = $clog2(N+1);

    logic [N-1:0]       occ_q, occ_d;
    logic [N-1:0]       al_vld_q, al_vld_d;
    logic [N-1:0]       cand, dl_vec;
    ob_pkg::cmd_t       al_cmd_q, out_cmd_q;
    logic               out_vld_q, err_q;
    logic [IDX_W-1:0]   out_idx_q, rr_q, free_idx, sel;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               acc, hs, ld_en, sel_vld;

    assign in_rdy = ~&occ_q;
    assign acc    = in_vld & in_rdy;
    assign hs     = out_vld_q & out_rdy;
    assign dl_vec = hs ? (N'(1) << out_idx_q) : '0;
    // An entry being deallocated this cycle must not be picked again.
    assign cand   = ent_mtr_vld_r & occ_q & ~dl_vec;
    assign ld_en  = ~out_vld_q | out_rdy;

    always_comb begin
        free_idx = '0;
        for (int i = N-1; i >= 0; i--) begin
            if (!occ_q[i]) free_idx = IDX_W'(i);
        end
    end

    always_comb begin : rr_pick
        logic [IDX_W-1:0] j;
        j       = '0;
        sel_vld = 1'b0;
        sel     = '0;
        for (int k = 0; k < N; k++) begin
            j = IDX_W'((int'(rr_q) + k) % N);
            if (!sel_vld && cand[j]) begin
                sel_vld = 1'b1;
                sel     = j;
            end
        end
    end

    always_comb begin
        occ_d    = occ_q & ~dl_vec;
        al_vld_d = '0;
        if (acc) begin
            occ_d[free_idx] = 1'b1;
            al_vld_d        = N'(1) << free_idx;
        end
        cnt_d = cnt_q + CNT_W'(acc) - CNT_W'(hs);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occ_q     <= '0;
            al_vld_q  <= '0;
            al_cmd_q  <= '0;
            out_vld_q <= 1'b0;
            out_cmd_q <= '0;
            out_idx_q <= '0;
            rr_q      <= '0;
            cnt_q     <= '0;
            err_q     <= 1'b0;
        end else begin
            occ_q    <= occ_d;
            al_vld_q <= al_vld_d;
            cnt_q    <= cnt_d;
            err_q    <= err_q | (|(ent_mtr_vld_r & ~occ_q));
            if (acc) al_cmd_q <= in_cmd;
            if (ld_en) begin
                out_vld_q <= sel_vld;
                if (sel_vld) begin
                    out_cmd_q <= ent_cmd_r[sel];
                    out_idx_q <= sel;
                    rr_q      <= IDX_W'((int'(sel) + 1) % N);
                end
            end
        end
    end

    assign ent_al_vld   = al_vld_q;
    assign ent_al_cmd_r = al_cmd_q;
    assign ent_dl_vld   = dl_vec;
    assign out_vld      = out_vld_q;
    assign out_cmd      = out_cmd_q;
    assign out_idx      = out_idx_q;
    assign occ_cnt_r    = cnt_q;
    assign full_r       = (cnt_q == CNT_W'(N));
    assign empty_r      = (cnt_q == '0);
    assign err_r        = err_q;
endmodule

// File: tb/tb_ob_cn_table_ctrl.sv
// Self-checking bench for ob_cn_table_ctrl: directed scenarios plus randomized traffic against a reference model.
module tb_ob_cn_table_ctrl;
    import ob_pkg::*;
    localparam int N = 8;
    localparam int IDX_W = $clog2(N);
    localparam int CNT_W = $clog2(N+1);

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 in_vld = 1'b0;
    cmd_t                 in_cmd = '0;
    logic                 in_rdy;
    logic [N-1:0]         ent_al_vld;
    cmd_t                 ent_al_cmd_r;
    logic [N-1:0]         ent_dl_vld;
    logic [N-1:0]         mtr = '0;
    cmd_t [N-1:0]         ent_cmd = '0;
    logic                 out_vld;
    cmd_t                 out_cmd;
    logic [IDX_W-1:0]     out_idx;
    logic                 out_rdy = 1'b0;
    logic [CNT_W-1:0]     occ_cnt_r;
    logic                 full_r, empty_r, err_r;

    int n_cmp = 0;
    int n_bad = 0;

    ob_cn_table_ctrl #(.N(N)) dut (
        .clk(clk), .rst_n(rst_n), .in_vld(in_vld), .in_cmd(in_cmd), .in_rdy(in_rdy),
        .ent_al_vld(ent_al_vld), .ent_al_cmd_r(ent_al_cmd_r), .ent_dl_vld(ent_dl_vld),
        .ent_mtr_vld_r(mtr), .ent_cmd_r(ent_cmd), .out_vld(out_vld), .out_cmd(out_cmd),
        .out_idx(out_idx), .out_rdy(out_rdy), .occ_cnt_r(occ_cnt_r), .full_r(full_r),
        .empty_r(empty_r), .err_r(err_r)
    );

    always #5 clk = ~clk;

    // Reference model: occupancy set, round-robin pointer, one-slot output register.
    bit   m_occ [N];
    int   m_age [N];
    bit   m_out_vld;
    int   m_out_idx;
    cmd_t m_out_cmd;
    int   m_rr;
    bit   m_err;
    int   m_al;
    cmd_t m_al_cmd;

    function automatic cmd_t rand_stop();
        cmd_t c;
        c.op    = opcode_t'(4'($urandom_range(5, 8)));
        c.oid   = 16'($urandom);
        c.price = $urandom;
        c.qty   = 16'($urandom_range(1, 65535));
        return c;
    endfunction

    function automatic cmd_t permute(cmd_t c);
        cmd_t r = c;
        case (c.op)
            OP_BUY_STOP_LOSS:   r.op = OP_BUY_MARKET;
            OP_SELL_STOP_LOSS:  r.op = OP_SELL_MARKET;
            OP_BUY_STOP_LIMIT:  r.op = OP_BUY_LIMIT;
            OP_SELL_STOP_LIMIT: r.op = OP_SELL_LIMIT;
            default:            r.op = c.op;
        endcase
        return r;
    endfunction

    function automatic int m_count();
        int c = 0;
        for (int i = 0; i < N; i++) c += int'(m_occ[i]);
        return c;
    endfunction

    task automatic m_reset();
        for (int i = 0; i < N; i++) begin m_occ[i] = 0; m_age[i] = 0; end
        m_out_vld = 0; m_out_idx = 0; m_out_cmd = '0; m_rr = 0; m_err = 0; m_al = -1; m_al_cmd = '0;
    endtask

    task automatic model_step();
        int dl, fr, found;
        dl = (m_out_vld && out_rdy) ? m_out_idx : -1;
        fr = -1;
        for (int i = 0; i < N; i++) if (!m_occ[i] && fr < 0) fr = i;
        for (int i = 0; i < N; i++) if (mtr[i] && !m_occ[i]) m_err = 1;
        if (!m_out_vld || out_rdy) begin
            found = -1;
            for (int k = 0; k < N; k++) begin
                int j = (m_rr + k) % N;
                if (found < 0 && mtr[j] && m_occ[j] && j != dl) found = j;
            end
            m_out_vld = (found >= 0);
            if (found >= 0) begin
                m_out_idx = found; m_out_cmd = ent_cmd[found]; m_rr = (found + 1) % N;
            end
        end
        if (dl >= 0) m_occ[dl] = 0;
        for (int i = 0; i < N; i++) m_age[i] = m_occ[i] ? m_age[i] + 1 : 0;
        m_al = (in_vld && fr >= 0) ? fr : -1;
        if (m_al >= 0) begin m_occ[fr] = 1; m_age[fr] = 0; m_al_cmd = in_cmd; end
    endtask

    // One clock: advance the model, then play the entries (capture on allocation, leave MATURED on deallocation).
    task automatic tick();
        int d;
        d = (m_out_vld && out_rdy) ? m_out_idx : -1;
        model_step();
        @(posedge clk); #1;
        if (d >= 0) mtr[d] = 1'b0;
        if (m_al >= 0) ent_cmd[m_al] = permute(m_al_cmd);
    endtask

    task automatic apply_reset();
        rst_n = 1'b0; in_vld = 1'b0; in_cmd = '0; out_rdy = 1'b0; mtr = '0; ent_cmd = '0;
        m_reset();
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        apply_reset();
        n_cmp++; if (in_rdy !== 1'b1 || empty_r !== 1'b1 || full_r !== 1'b0 || occ_cnt_r !== '0) begin
            n_bad++; $display("FAIL reset_idle: in_rdy=%b empty=%b full=%b cnt=%0d want 1 1 0 0", in_rdy, empty_r, full_r, occ_cnt_r);
        end
        in_vld = 1'b1; in_cmd = rand_stop(); tick();
        in_vld = 1'b0; tick(); tick();
        mtr[0] = 1'b1; out_rdy = 1'b0; tick();
        n_cmp++; if (out_vld !== 1'b1 || out_idx !== 3'd0) begin
            n_bad++; $display("FAIL reset_pre_vld: out_vld=%b idx=%0d want 1 0", out_vld, out_idx);
        end
        #2 rst_n = 1'b0; mtr = '0; out_rdy = 1'b1;
        #1;
        n_cmp++; if (out_vld !== 1'b0 || out_cmd !== '0 || out_idx !== '0 || ent_al_vld !== '0 ||
                     ent_al_cmd_r !== '0 || ent_dl_vld !== '0 || in_rdy !== 1'b1) begin
            n_bad++; $display("FAIL reset_async_out: vld=%b cmd=%h idx=%0d al=%h alcmd=%h dl=%h rdy=%b want all zero, rdy=1",
                              out_vld, out_cmd, out_idx, ent_al_vld, ent_al_cmd_r, ent_dl_vld, in_rdy);
        end
        n_cmp++; if (occ_cnt_r !== '0 || full_r !== 1'b0 || empty_r !== 1'b1 || err_r !== 1'b0) begin
            n_bad++; $display("FAIL reset_async_stat: cnt=%0d full=%b empty=%b err=%b want 0 0 1 0", occ_cnt_r, full_r, empty_r, err_r);
        end
        apply_reset();
        n_cmp++; if (in_rdy !== 1'b1 || empty_r !== 1'b1) begin
            n_bad++; $display("FAIL reset_release: in_rdy=%b empty=%b want 1 1", in_rdy, empty_r);
        end
    endtask

    task automatic test_fill();
        cmd_t c;
        apply_reset();
        for (int k = 0; k < N; k++) begin
            c = rand_stop(); c.op = OP_BUY_STOP_LOSS;
            in_vld = 1'b1; in_cmd = c; #1;
            n_cmp++; if (in_rdy !== 1'b1) begin n_bad++; $display("FAIL fill_rdy[%0d]: got %b want 1", k, in_rdy); end
            tick();
            n_cmp++; if (ent_al_vld !== (N'(1) << k) || ent_al_cmd_r !== c) begin
                n_bad++; $display("FAIL fill_al[%0d]: al=%h cmd=%h want %h %h", k, ent_al_vld, ent_al_cmd_r, N'(1) << k, c);
            end
        end
        n_cmp++; if (full_r !== 1'b1 || in_rdy !== 1'b0 || occ_cnt_r !== CNT_W'(N)) begin
            n_bad++; $display("FAIL fill_full: full=%b in_rdy=%b cnt=%0d want 1 0 %0d", full_r, in_rdy, occ_cnt_r, N);
        end
        in_cmd = rand_stop(); tick(); tick();
        n_cmp++; if (ent_al_vld !== '0 || occ_cnt_r !== CNT_W'(N)) begin
            n_bad++; $display("FAIL fill_stall: al=%h cnt=%0d want 0 %0d", ent_al_vld, occ_cnt_r, N);
        end
        in_vld = 1'b0;
    endtask

    task automatic test_round_robin();
        int exp_idx [3] = '{2, 5, 6};
        out_rdy = 1'b1; mtr = 8'b0110_0100; tick();
        for (int k = 0; k < 3; k++) begin
            n_cmp++; if (out_vld !== 1'b1 || out_idx !== IDX_W'(exp_idx[k]) || out_cmd !== ent_cmd[exp_idx[k]] ||
                         ent_dl_vld !== (N'(1) << exp_idx[k])) begin
                n_bad++; $display("FAIL rr_issue[%0d]: vld=%b idx=%0d cmd=%h dl=%h want 1 %0d %h %h", k, out_vld, out_idx,
                                  out_cmd, ent_dl_vld, exp_idx[k], ent_cmd[exp_idx[k]], N'(1) << exp_idx[k]);
            end
            tick();
        end
        n_cmp++; if (out_vld !== 1'b0 || ent_dl_vld !== '0 || occ_cnt_r !== CNT_W'(N-3)) begin
            n_bad++; $display("FAIL rr_done: vld=%b dl=%h cnt=%0d want 0 0 %0d", out_vld, ent_dl_vld, occ_cnt_r, N-3);
        end
    endtask

    task automatic test_backpressure();
        cmd_t held;
        out_rdy = 1'b0; mtr[3] = 1'b1; tick();
        held = ent_cmd[3];
        for (int k = 0; k < 4; k++) begin
            n_cmp++; if (out_vld !== 1'b1 || out_idx !== 3'd3 || out_cmd !== held || ent_dl_vld !== '0) begin
                n_bad++; $display("FAIL bp_hold[%0d]: vld=%b idx=%0d cmd=%h dl=%h want 1 3 %h 0", k, out_vld, out_idx, out_cmd, ent_dl_vld, held);
            end
            tick();
        end
        out_rdy = 1'b1; #1;
        n_cmp++; if (ent_dl_vld !== 8'h08) begin n_bad++; $display("FAIL bp_release: dl=%h want 08", ent_dl_vld); end
        tick();
        n_cmp++; if (ent_dl_vld !== '0 || out_vld !== 1'b0 || occ_cnt_r !== CNT_W'(N-4)) begin
            n_bad++; $display("FAIL bp_single: dl=%h vld=%b cnt=%0d want 0 0 %0d", ent_dl_vld, out_vld, occ_cnt_r, N-4);
        end
    endtask

    task automatic test_full_swap();
        apply_reset();
        in_vld = 1'b1;
        for (int k = 0; k < N; k++) begin in_cmd = rand_stop(); tick(); end
        tick();
        out_rdy = 1'b1; mtr[0] = 1'b1; in_cmd = rand_stop(); tick();
        n_cmp++; if (in_rdy !== 1'b0 || ent_dl_vld !== 8'h01 || out_vld !== 1'b1) begin
            n_bad++; $display("FAIL swap_hs: in_rdy=%b dl=%h vld=%b want 0 01 1", in_rdy, ent_dl_vld, out_vld);
        end
        tick();
        n_cmp++; if (ent_al_vld !== '0 || in_rdy !== 1'b1) begin
            n_bad++; $display("FAIL swap_free: al=%h in_rdy=%b want 0 1", ent_al_vld, in_rdy);
        end
        tick();
        in_vld = 1'b0;
        n_cmp++; if (ent_al_vld !== 8'h01 || occ_cnt_r !== CNT_W'(N) || full_r !== 1'b1) begin
            n_bad++; $display("FAIL swap_accept: al=%h cnt=%0d full=%b want 01 %0d 1", ent_al_vld, occ_cnt_r, N, full_r);
        end
    endtask

    task automatic test_error();
        bit issued4 = 0;
        apply_reset();
        in_vld = 1'b1; in_cmd = rand_stop(); tick(); in_cmd = rand_stop(); tick(); in_vld = 1'b0;
        n_cmp++; if (err_r !== 1'b0) begin n_bad++; $display("FAIL err_clean: got %b want 0", err_r); end
        out_rdy = 1'b1; mtr[4] = 1'b1; tick();
        n_cmp++; if (err_r !== 1'b1) begin n_bad++; $display("FAIL err_set: got %b want 1", err_r); end
        for (int k = 0; k < 5; k++) begin
            if (out_vld === 1'b1 && out_idx === 3'd4) issued4 = 1;
            tick();
        end
        mtr[4] = 1'b0; tick(); tick();
        n_cmp++; if (err_r !== 1'b1 || issued4 || out_vld !== 1'b0) begin
            n_bad++; $display("FAIL err_sticky: err=%b issued4=%b vld=%b want 1 0 0", err_r, issued4, out_vld);
        end
    endtask

    task automatic test_random();
        logic [N-1:0] exp_dl, exp_al;
        bit exp_rdy;
        int cnt;
        apply_reset();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            in_vld  = ($urandom_range(0, 99) < 55);
            in_cmd  = rand_stop();
            out_rdy = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < N; i++)
                if (m_occ[i] && m_age[i] >= 2 && !mtr[i] && $urandom_range(0, 4) == 0) mtr[i] = 1'b1;
            #1;
            exp_rdy = 0;
            for (int i = 0; i < N; i++) if (!m_occ[i]) exp_rdy = 1;
            exp_dl = (m_out_vld && out_rdy) ? (N'(1) << m_out_idx) : '0;
            exp_al = (m_al >= 0) ? (N'(1) << m_al) : '0;
            cnt = m_count();
            n_cmp++; if (in_rdy !== exp_rdy || ent_dl_vld !== exp_dl || ent_al_vld !== exp_al) begin
                n_bad++; $display("FAIL rnd_hs@%0d: rdy=%b dl=%h al=%h want %b %h %h", cyc, in_rdy, ent_dl_vld, ent_al_vld, exp_rdy, exp_dl, exp_al);
            end
            n_cmp++; if (out_vld !== m_out_vld || (m_out_vld && (out_idx !== IDX_W'(m_out_idx) || out_cmd !== m_out_cmd))) begin
                n_bad++; $display("FAIL rnd_out@%0d: vld=%b idx=%0d cmd=%h want %b %0d %h", cyc, out_vld, out_idx, out_cmd, m_out_vld, m_out_idx, m_out_cmd);
            end
            n_cmp++; if (occ_cnt_r !== CNT_W'(cnt) || full_r !== (cnt == N) || empty_r !== (cnt == 0) ||
                         err_r !== m_err || ent_al_cmd_r !== m_al_cmd) begin
                n_bad++; $display("FAIL rnd_stat@%0d: cnt=%0d full=%b empty=%b err=%b alcmd=%h want %0d %b %b %b %h", cyc, occ_cnt_r,
                                  full_r, empty_r, err_r, ent_al_cmd_r, cnt, cnt == N, cnt == 0, m_err, m_al_cmd);
            end
            tick();
        end
        in_vld = 1'b0;
    endtask

    initial begin
        m_reset();
        test_reset();
        test_fill();
        test_round_robin();
        test_backpressure();
        test_full_swap();
        test_error();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, want finish before limit");
        $fatal(1);
    end
endmodule
